// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types and sizing helpers for the parametrised synchronous FIFO.
//   cnt_w(depth) : width of an occupancy counter able to hold 0..depth
//   ptr_w(depth) : width of a pointer addressing 0..depth-1 (at least 1 bit)
//   fifo_err_t   : sticky error status {ovf, udf}
// ---------------------------------------------------------------------------
package fifo_pkg;

   typedef struct packed {
      logic ovf;   // a write was rejected because the FIFO was full
      logic udf;   // a read was rejected because the FIFO was empty
   } fifo_err_t;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk        in   clock
//   i_wr_en    in   write strobe
//   i_wr_addr  in   write address (0..DEPTH-1)
//   i_wr_data  in   write data
//   i_rd_addr  in   read address (0..DEPTH-1)
//   o_rd_data  out  word at i_rd_addr (combinational)
// ---------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      i_wr_en,
   input  logic [ptr_w(DEPTH)-1:0]   i_wr_addr,
   input  logic [WIDTH-1:0]          i_wr_data,
   input  logic [ptr_w(DEPTH)-1:0]   i_rd_addr,
   output logic [WIDTH-1:0]          o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Storage write port
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_mem

// File: rtl/fifo_param.sv
// ---------------------------------------------------------------------------
// fifo_param
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// margins, occupancy count, sticky error status and optional
// first-word-fall-through read mode.
// Ports:
//   clk, rst      in   clock, synchronous active-high reset
//   wr_en         in   write request
//   data_in       in   write data
//   rd_en         in   read request
//   err_clr       in   clears err_sticky (a same-cycle new error wins)
//   data_out      out  read data (registered, or head word when FWFT=1)
//   rd_valid      out  data_out holds a valid word
//   wr_ack        out  pulse per accepted write
//   overflow      out  pulse per rejected write
//   underflow     out  pulse per rejected read
//   full, almostfull, empty, almostempty  out  occupancy flags
//   count         out  current occupancy
//   err_sticky    out  {ovf, udf} sticky error bits
// ---------------------------------------------------------------------------
module fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 8,
   parameter int AF_MARGIN = 1,
   parameter int AE_MARGIN = 1,
   parameter int FWFT      = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [WIDTH-1:0]          data_in,
   input  logic                      rd_en,
   input  logic                      err_clr,
   output logic [WIDTH-1:0]          data_out,
   output logic                      rd_valid,
   output logic                      wr_ack,
   output logic                      overflow,
   output logic                      underflow,
   output logic                      full,
   output logic                      almostfull,
   output logic                      empty,
   output logic                      almostempty,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output fifo_err_t                 err_sticky
);

   localparam int CW = cnt_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);

   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF    = CW'(DEPTH - AF_MARGIN);
   localparam logic [CW-1:0] CNT_AE    = CW'(AE_MARGIN);
   localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

   // Parameter legality, caught at elaboration
   if (WIDTH < 1) begin : g_bad_width
      $error("fifo_param: WIDTH must be >= 1");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_param: DEPTH must be >= 2");
   end
   if ((AF_MARGIN < 1) || (AF_MARGIN > DEPTH - 1)) begin : g_bad_af
      $error("fifo_param: AF_MARGIN must be in 1..DEPTH-1");
   end
   if ((AE_MARGIN < 1) || (AE_MARGIN > DEPTH - 1)) begin : g_bad_ae
      $error("fifo_param: AE_MARGIN must be in 1..DEPTH-1");
   end
   if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
      $error("fifo_param: FWFT must be 0 or 1");
   end

   // Pointers wrap explicitly so DEPTH need not be a power of two
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? PTR_ZERO : (p + PTR_ONE);
   endfunction

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_data_out;
   logic             r_rd_valid;
   logic             r_wr_ack;
   logic             r_overflow;
   logic             r_underflow;
   fifo_err_t        r_err;

   logic             w_full;
   logic             w_empty;
   logic             w_wr_acc;
   logic             w_rd_acc;
   logic             w_wr_rej;
   logic             w_rd_rej;
   logic [WIDTH-1:0] w_rd_data;

   // Flags come from the registered count only, so requests never reach outputs
   assign w_full   = (r_count == CNT_FULL);
   assign w_empty  = (r_count == CNT_ZERO);

   // A full FIFO rejects writes even with a concurrent read; an empty FIFO
   // rejects reads even with a concurrent write
   assign w_wr_acc = wr_en && !w_full;
   assign w_wr_rej = wr_en &&  w_full;
   assign w_rd_acc = rd_en && !w_empty;
   assign w_rd_rej = rd_en &&  w_empty;

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_acc && !rst),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (data_in),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   // Pointer and occupancy state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= PTR_ZERO;
         r_rd_ptr <= PTR_ZERO;
         r_count  <= CNT_ZERO;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered read port and one-cycle event pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_out  <= {WIDTH{1'b0}};
         r_rd_valid  <= 1'b0;
         r_wr_ack    <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_rd_acc) begin
            r_data_out <= w_rd_data;
         end
         r_rd_valid  <= w_rd_acc;
         r_wr_ack    <= w_wr_acc;
         r_overflow  <= w_wr_rej;
         r_underflow <= w_rd_rej;
      end
   end

   // Sticky error bits: a new error in the clear cycle keeps the bit set
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= '{ovf: 1'b0, udf: 1'b0};
      end else begin
         r_err.ovf <= w_wr_rej | (r_err.ovf & ~err_clr);
         r_err.udf <= w_rd_rej | (r_err.udf & ~err_clr);
      end
   end

   // Read-data presentation: head word in FWFT mode, registered word otherwise
   always_comb begin
      data_out = r_data_out;
      rd_valid = r_rd_valid;
      if (FWFT != 0) begin
         data_out = w_empty ? {WIDTH{1'b0}} : w_rd_data;
         rd_valid = !w_empty;
      end else begin
         data_out = r_data_out;
         rd_valid = r_rd_valid;
      end
   end

   assign wr_ack      = r_wr_ack;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;
   assign full        = w_full;
   assign empty       = w_empty;
   assign almostfull  = (r_count >= CNT_AF) && (r_count < CNT_FULL);
   assign almostempty = !w_empty && (r_count <= CNT_AE);
   assign count       = r_count;
   assign err_sticky  = r_err;

endmodule : fifo_param

// File: tb/tb_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_param
// Directed bench for fifo_param. Three instances:
//   u_dut   : DEPTH=8, margins 1, registered read
//   u_dut_m : DEPTH=8, AF_MARGIN=3, AE_MARGIN=2 (shares u_dut's stimulus)
//   u_dut_f : DEPTH=5, FWFT=1 (own stimulus)
// ---------------------------------------------------------------------------
module tb_fifo_param;

   logic        clk;
   logic        rst;

   // Stimulus shared by u_dut and u_dut_m
   logic        wr_en;
   logic [15:0] data_in;
   logic        rd_en;
   logic        err_clr;

   logic [15:0] a_dout;
   logic        a_rv, a_ack, a_ovf, a_udf, a_full, a_af, a_empty, a_ae;
   logic [3:0]  a_cnt;
   logic [1:0]  a_err;

   logic [15:0] m_dout;
   logic        m_rv, m_ack, m_ovf, m_udf, m_full, m_af, m_empty, m_ae;
   logic [3:0]  m_cnt;
   logic [1:0]  m_err;

   // FWFT instance stimulus and outputs
   logic        f_wr_en;
   logic [15:0] f_data_in;
   logic        f_rd_en;
   logic        f_err_clr;
   logic [15:0] f_dout;
   logic        f_rv, f_ack, f_ovf, f_udf, f_full, f_af, f_empty, f_ae;
   logic [2:0]  f_cnt;
   logic [1:0]  f_err;

   int checks;
   int errors;

   fifo_param #(.WIDTH(16), .DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(0)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .err_clr(err_clr), .data_out(a_dout), .rd_valid(a_rv), .wr_ack(a_ack),
      .overflow(a_ovf), .underflow(a_udf), .full(a_full), .almostfull(a_af),
      .empty(a_empty), .almostempty(a_ae), .count(a_cnt), .err_sticky(a_err)
   );

   fifo_param #(.WIDTH(16), .DEPTH(8), .AF_MARGIN(3), .AE_MARGIN(2), .FWFT(0)) u_dut_m (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .err_clr(err_clr), .data_out(m_dout), .rd_valid(m_rv), .wr_ack(m_ack),
      .overflow(m_ovf), .underflow(m_udf), .full(m_full), .almostfull(m_af),
      .empty(m_empty), .almostempty(m_ae), .count(m_cnt), .err_sticky(m_err)
   );

   fifo_param #(.WIDTH(16), .DEPTH(5), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(1)) u_dut_f (
      .clk(clk), .rst(rst), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
      .err_clr(f_err_clr), .data_out(f_dout), .rd_valid(f_rv), .wr_ack(f_ack),
      .overflow(f_ovf), .underflow(f_udf), .full(f_full), .almostfull(f_af),
      .empty(f_empty), .almostempty(f_ae), .count(f_cnt), .err_sticky(f_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      err_clr   = 1'b0;
      data_in   = 16'h0000;
      f_wr_en   = 1'b0;
      f_rd_en   = 1'b0;
      f_err_clr = 1'b0;
      f_data_in = 16'h0000;

      // ---- reset state ----
      step();
      step();
      check_val("rst_count", 32'(a_cnt), 32'd0);
      check_val("rst_empty", 32'(a_empty), 32'd1);
      check_val("rst_full", 32'(a_full), 32'd0);
      check_val("rst_ae", 32'(a_ae), 32'd0);
      check_val("rst_dout", 32'(a_dout), 32'd0);
      check_val("rst_err", 32'(a_err), 32'd0);
      check_val("rst_f_rv", 32'(f_rv), 32'd0);
      rst = 1'b0;

      // ---- fill: 8 writes of 1..8 ----
      for (int i = 1; i <= 8; i++) begin
         wr_en   = 1'b1;
         data_in = 16'(i);
         step();
         check_val($sformatf("fill_ack%0d", i), 32'(a_ack), 32'd1);
         check_val($sformatf("fill_cnt%0d", i), 32'(a_cnt), 32'(i));
         check_val($sformatf("fill_af%0d", i), 32'(a_af), (i == 7) ? 32'd1 : 32'd0);
         check_val($sformatf("fill_ae%0d", i), 32'(a_ae), (i == 1) ? 32'd1 : 32'd0);
         check_val($sformatf("fill_full%0d", i), 32'(a_full), (i == 8) ? 32'd1 : 32'd0);
         check_val($sformatf("m_af%0d", i), 32'(m_af), (i >= 5 && i <= 7) ? 32'd1 : 32'd0);
         check_val($sformatf("m_ae%0d", i), 32'(m_ae), (i <= 2) ? 32'd1 : 32'd0);
      end

      // ---- overflow: 3 writes while full ----
      data_in = 16'h0055;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val($sformatf("ovf_pulse%0d", i), 32'(a_ovf), 32'd1);
         check_val($sformatf("ovf_ack%0d", i), 32'(a_ack), 32'd0);
         check_val($sformatf("ovf_cnt%0d", i), 32'(a_cnt), 32'd8);
         check_val($sformatf("ovf_err%0d", i), 32'(a_err), 32'h2);
      end
      wr_en = 1'b0;
      step();
      check_val("ovf_end", 32'(a_ovf), 32'd0);
      check_val("ovf_hold", 32'(a_err), 32'h2);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_val("err_clr", 32'(a_err), 32'h0);

      // ---- drain: 8 reads, expect 1..8 in order ----
      for (int i = 1; i <= 8; i++) begin
         rd_en = 1'b1;
         step();
         check_val($sformatf("drain_rv%0d", i), 32'(a_rv), 32'd1);
         check_val($sformatf("drain_dout%0d", i), 32'(a_dout), 32'(i));
         check_val($sformatf("drain_cnt%0d", i), 32'(a_cnt), 32'(8 - i));
         check_val($sformatf("drain_empty%0d", i), 32'(a_empty), (i == 8) ? 32'd1 : 32'd0);
         check_val($sformatf("m_ae_d%0d", i), 32'(m_ae), (i == 6 || i == 7) ? 32'd1 : 32'd0);
      end
      rd_en = 1'b0;
      step();
      check_val("drain_rv_end", 32'(a_rv), 32'd0);
      check_val("drain_dout_hold", 32'(a_dout), 32'd8);
      check_val("drain_err", 32'(a_err), 32'h0);

      // ---- underflow with simultaneous write ----
      rd_en   = 1'b1;
      wr_en   = 1'b1;
      data_in = 16'hBEEF;
      step();
      check_val("udf_pulse", 32'(a_udf), 32'd1);
      check_val("udf_ack", 32'(a_ack), 32'd1);
      check_val("udf_cnt", 32'(a_cnt), 32'd1);
      check_val("udf_rv", 32'(a_rv), 32'd0);
      check_val("udf_err", 32'(a_err), 32'h1);
      wr_en = 1'b0;
      step();
      check_val("udf_rd_dout", 32'(a_dout), 32'h0000BEEF);
      check_val("udf_rd_rv", 32'(a_rv), 32'd1);
      check_val("udf_rd_cnt", 32'(a_cnt), 32'd0);
      check_val("udf_end", 32'(a_udf), 32'd0);
      rd_en = 1'b0;

      // ---- reset mid-burst at count 6 ----
      for (int i = 0; i < 6; i++) begin
         wr_en   = 1'b1;
         data_in = 16'(16'h0100 + i);
         step();
      end
      check_val("pre_rst_cnt", 32'(a_cnt), 32'd6);
      rst     = 1'b1;
      data_in = 16'h0777;
      rd_en   = 1'b1;
      step();
      check_val("mid_rst_cnt", 32'(a_cnt), 32'd0);
      check_val("mid_rst_empty", 32'(a_empty), 32'd1);
      check_val("mid_rst_ack", 32'(a_ack), 32'd0);
      check_val("mid_rst_rv", 32'(a_rv), 32'd0);
      check_val("mid_rst_dout", 32'(a_dout), 32'd0);
      check_val("mid_rst_err", 32'(a_err), 32'h0);
      rst     = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b1;
      data_in = 16'hA5A5;
      step();
      check_val("post_rst_cnt", 32'(a_cnt), 32'd1);
      wr_en = 1'b0;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check_val("post_rst_dout", 32'(a_dout), 32'h0000A5A5);
      check_val("post_rst_empty", 32'(a_empty), 32'd1);

      // ---- FWFT, DEPTH=5: interleaved traffic across pointer wrap ----
      f_wr_en   = 1'b1;
      f_data_in = 16'h0010;
      step();
      check_val("f_first_rv", 32'(f_rv), 32'd1);
      check_val("f_first_dout", 32'(f_dout), 32'h10);
      check_val("f_first_cnt", 32'(f_cnt), 32'd1);
      for (int k = 0; k < 12; k++) begin
         f_wr_en   = 1'b1;
         f_rd_en   = 1'b1;
         f_data_in = 16'(16'h0011 + k);
         check_val($sformatf("f_head%0d", k), 32'(f_dout), 32'(16'h0010 + k));
         step();
         check_val($sformatf("f_cnt%0d", k), 32'(f_cnt), 32'd1);
         check_val($sformatf("f_rv%0d", k), 32'(f_rv), 32'd1);
         check_val($sformatf("f_next%0d", k), 32'(f_dout), 32'(16'h0011 + k));
      end
      f_wr_en = 1'b0;
      f_rd_en = 1'b1;
      step();
      f_rd_en = 1'b0;
      check_val("f_last_empty", 32'(f_empty), 32'd1);
      check_val("f_last_rv", 32'(f_rv), 32'd0);
      check_val("f_err", 32'(f_err), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fifo_param
